ahb_slave_port: RTL and testbench
=================================

Name: ahb_slave_port

Overview:
- AHB slave-side interface, the responder for transfers issued by the AHB master port.
- Accepts address/control from the bus and drives HREADYOUT, HRESP and HRDATA.
- Converts each accepted transfer into a single req/ack transaction on a simple peripheral interface (register file, SRAM or bridge).
- One instance per slave slot behind the AHB decoder/mux.

Parameters:
- ADDR_W, 12, peripheral address width; slave window is 2^ADDR_W bytes.
- MEM_BYTES, 4096, implemented size in bytes; offsets >= MEM_BYTES get an ERROR response.
- TIMEOUT_CYC, 255, wait cycles before forced ERROR (only with the optional feature).

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; values above 2 are illegal.
- HBURST  in  3  ignored except for debug capture.
- HWDATA  in  32  data-phase write data.
- HREADY  in  1  bus-level ready (mux output).
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  2  OKAY=00, ERROR=01; RETRY and SPLIT are never driven.
- HRDATA  out  32  read data.
- per_req  out  1  peripheral request, held until per_ack.
- per_write  out  1  request is a write.
- per_addr  out  ADDR_W  word-aligned byte address.
- per_be  out  4  byte enables, little-endian.
- per_wdata  out  32  write data (HWDATA passthrough while per_req=1).
- per_ack  in  1  peripheral completion; per_rdata and per_err are valid in the same cycle.
- per_rdata  in  32  read data.
- per_err  in  1  peripheral error.

Behaviour:
- Reset values (asynchronous, including mid-transfer): HREADYOUT=1, HRESP=00, HRDATA=0, per_req=0, per_write=0, per_addr=0, per_be=0, state IDLE.
  - An outstanding peripheral request is dropped without waiting for per_ack.
- Address-phase capture: on the HCLK edge where HSEL & HREADY & HTRANS[1].
  - Registers HWRITE, HSIZE, HADDR[ADDR_W-1:0] and the computed byte enables.
- Legality check at capture:
  - HSIZE > 2, misaligned access (half with addr[0]=1, word with addr[1:0]!=0), or offset >= MEM_BYTES: go to ERR1; no per_req.
  - Otherwise go to WAIT.
- Byte enables:
  - byte: 1 << addr[1:0]
  - half: 0011 or 1100 (by addr[1])
  - word: 1111
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=OKAY. IDLE/BUSY or unselected transfers get a zero-wait OKAY.
  - WAIT: per_req=1, HREADYOUT=0.
    - per_ack & !per_err: latch per_rdata into HRDATA (reads only; writes leave HRDATA unchanged), go to DONE.
    - per_ack & per_err: go to ERR1.
    - per_req drops in the cycle after ack.
  - DONE: HREADYOUT=1, HRESP=OKAY for one cycle. A new address phase may be captured in this same cycle (pipelined) and goes to WAIT/ERR1; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR, one cycle, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR, one cycle. A capture is allowed as in DONE; otherwise go to IDLE.
- Latency:
  - Minimum data phase is 2 cycles (req cycle + DONE) with ack in the first WAIT cycle.
  - Each extra cycle without per_ack adds one wait state.
- HWDATA is sampled by the peripheral only while per_req=1. The AHB guarantee that data stays stable in the data phase is relied upon; HWDATA is not registered.
- A capture is impossible in WAIT or ERR1 because HREADY is low. HSEL/HTRANS changes there are ignored.
- per_ack outside WAIT is ignored.

Optional Feature:
- Macro AHB_SLAVE_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without per_ack: drop per_req and go to ERR1.
  - A per_ack arriving in the same cycle as the timeout wins.
- Undefined: no counter; WAIT persists indefinitely until per_ack.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HRESP codes (OKAY/ERROR/RETRY/SPLIT), HSIZE codes.
  - Slave FSM state encoding (IDLE, WAIT, DONE, ERR1, ERR2).
- One sub-module: ahb_slave_be_decode, combinational, mapping HSIZE + addr[1:0] to per_be plus an illegal flag. It is reusable by other slaves.

Test Plan:
- Word write 0x0000_0010 = 0xDEADBEEF, ack on first WAIT cycle:
  - per_req=1 for 1 cycle, per_be=1111, per_wdata=0xDEADBEEF.
  - HREADYOUT low 1 cycle, HRESP=OKAY.
- Byte read at 0x13, per_rdata=0x11223344, ack after 3 waits:
  - per_be=1000.
  - HREADYOUT low 4 cycles, then HRDATA=0x11223344 with HREADYOUT=1.
- Word access at 0x0000_0002:
  - no per_req; HRESP=01 with HREADYOUT 0 then 1.
  - Next NONSEQ captured in the ERR2 cycle.
- Peripheral per_err on a read: two-cycle ERROR response (HREADYOUT 0,1); HRDATA unchanged.
- Back-to-back NONSEQ write then read: second address captured in the DONE cycle; no IDLE cycle between the two per_req pulses.
- HRESETn asserted during WAIT: per_req=0 and HREADYOUT=1 immediately (asynchronous).
  - With AHB_SLAVE_TIMEOUT_EN and TIMEOUT_CYC=4, no ack: ERROR after 4 WAIT cycles.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB protocol codes and the slave-port FSM encoding, shared by AHB slave blocks.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    SLV_IDLE = 3'd0,
    SLV_WAIT = 3'd1,
    SLV_DONE = 3'd2,
    SLV_ERR1 = 3'd3,
    SLV_ERR2 = 3'd4
  } slv_state_e;

endpackage

// File: rtl/ahb_slave_be_decode.sv
// Maps HSIZE and the low address bits to little-endian byte enables; flags
// illegal sizes and misaligned accesses (byte enables are zero when illegal).
module ahb_slave_be_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       illegal
);

  // Size/alignment decode
  always_comb begin
    be      = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        if (addr_lo[0]) begin
          illegal = 1'b1;
        end else begin
          be = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
      end
      HSIZE_WORD: begin
        if (addr_lo != 2'b00) begin
          illegal = 1'b1;
        end else begin
          be = 4'b1111;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_slave_port.sv
// AHB slave port: each accepted transfer becomes one req/ack peripheral transaction.
// Optional WAIT-state timeout forcing an ERROR response: define AHB_SLAVE_TIMEOUT_EN.
module ahb_slave_port
  import ahb_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 4096
`ifdef AHB_SLAVE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA,
  output logic              per_req,
  output logic              per_write,
  output logic [ADDR_W-1:0] per_addr,
  output logic [3:0]        per_be,
  output logic [31:0]       per_wdata,
  input  logic              per_ack,
  input  logic [31:0]       per_rdata,
  input  logic              per_err
);

  slv_state_e state_r;
  slv_state_e state_s;
  logic       can_cap_s;
  logic       capture_s;
  logic       size_bad_s;
  logic       range_bad_s;
  logic       illegal_s;
  logic       timeout_s;
  logic [3:0] be_s;
  logic       unused_ok_s;

  // Captures only happen while this slave shows HREADYOUT=1 (IDLE, DONE, ERR2)
  assign can_cap_s   = (state_r == SLV_IDLE) || (state_r == SLV_DONE) || (state_r == SLV_ERR2);
  assign capture_s   = can_cap_s & HSEL & HREADY & HTRANS[1];
  assign range_bad_s = 32'(HADDR[ADDR_W-1:0]) >= 32'(MEM_BYTES);
  assign illegal_s   = size_bad_s | range_bad_s;
  assign per_wdata   = per_req ? HWDATA : 32'h0000_0000;
  assign unused_ok_s = ^{HTRANS[0], HBURST, HADDR[31:ADDR_W]};

  ahb_slave_be_decode u_be_decode (
    .hsize   (HSIZE),
    .addr_lo (HADDR[1:0]),
    .be      (be_s),
    .illegal (size_bad_s)
  );

`ifdef AHB_SLAVE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_r;

  assign timeout_s = (state_r == SLV_WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // WAIT-cycle counter, cleared on every entry to WAIT
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_r <= '0;
    end else if ((state_s == SLV_WAIT) && (state_r != SLV_WAIT)) begin
      wait_cnt_r <= '0;
    end else if (state_r == SLV_WAIT) begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic; a same-cycle ack beats the timeout
  always_comb begin
    state_s = state_r;
    case (state_r)
      SLV_IDLE, SLV_DONE, SLV_ERR2: begin
        if (capture_s) begin
          state_s = illegal_s ? SLV_ERR1 : SLV_WAIT;
        end else begin
          state_s = SLV_IDLE;
        end
      end
      SLV_WAIT: begin
        if (per_ack) begin
          state_s = per_err ? SLV_ERR1 : SLV_DONE;
        end else if (timeout_s) begin
          state_s = SLV_ERR1;
        end else begin
          state_s = SLV_WAIT;
        end
      end
      SLV_ERR1: state_s = SLV_ERR2;
      default:  state_s = SLV_IDLE;
    endcase
  end

  // State and bus/peripheral handshake outputs, registered from the next state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r   <= SLV_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      per_req   <= 1'b0;
    end else begin
      state_r   <= state_s;
      HREADYOUT <= (state_s == SLV_IDLE) || (state_s == SLV_DONE) || (state_s == SLV_ERR2);
      HRESP     <= ((state_s == SLV_ERR1) || (state_s == SLV_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      per_req   <= (state_s == SLV_WAIT);
    end
  end

  // Address-phase capture and read-data latch
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      per_write <= 1'b0;
      per_addr  <= '0;
      per_be    <= 4'b0000;
      HRDATA    <= 32'h0000_0000;
    end else begin
      if (capture_s) begin
        per_write <= HWRITE;
        per_addr  <= {HADDR[ADDR_W-1:2], 2'b00};
        per_be    <= be_s;
      end else begin
        per_write <= per_write;
        per_addr  <= per_addr;
        per_be    <= per_be;
      end
      if ((state_r == SLV_WAIT) && per_ack && !per_err && !per_write) begin
        HRDATA <= per_rdata;
      end else begin
        HRDATA <= HRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_port.sv
// Scoreboard bench for ahb_slave_port: an AHB master drives a directed transfer table,
// a peripheral responder checks requests, and a bus monitor checks each completion.
module tb_ahb_slave_port;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        per_req;
  logic        per_write;
  logic [11:0] per_addr;
  logic [3:0]  per_be;
  logic [31:0] per_wdata;
  logic        per_ack;
  logic [31:0] per_rdata;
  logic        per_err;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_slave_port #(
    .ADDR_W(12),
    .MEM_BYTES(2048)
`ifdef AHB_SLAVE_TIMEOUT_EN
    , .TIMEOUT_CYC(4)
`endif
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .per_req(per_req), .per_write(per_write), .per_addr(per_addr), .per_be(per_be),
    .per_wdata(per_wdata), .per_ack(per_ack), .per_rdata(per_rdata), .per_err(per_err)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          gap;
    int          dly;
    logic [31:0] rdata;
    logic        perr;
    logic        legal;
    logic [11:0] paddr;
    logic [3:0]  be;
    logic [1:0]  resp;
    int          waits;
    logic [31:0] hrdata;
  } item_t;

  typedef struct {
    logic [1:0]  resp;
    int          waits;
    logic [31:0] hrdata;
  } bus_exp_t;

  typedef struct {
    logic        wr;
    logic [11:0] paddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rdata;
    logic        perr;
  } per_exp_t;

  item_t    items[$];
  bus_exp_t bus_q[$];
  per_exp_t per_q[$];
  int       total = 0;
  int       bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input int gap, input int dly,
                     input logic [31:0] rdata, input logic perr, input logic legal,
                     input logic [11:0] paddr, input logic [3:0] be, input logic [1:0] resp,
                     input int waits, input logic [31:0] hrdata);
    items.push_back('{wr, addr, size, wdata, gap, dly, rdata, perr, legal, paddr, be, resp,
                      waits, hrdata});
  endtask

  // Peripheral responder: checks each new request, acks after the listed delay
  initial begin
    bit       serving;
    int       cnt;
    per_exp_t cur;
    serving   = 1'b0;
    cnt       = 0;
    cur       = '{1'b0, 12'h000, 4'h0, 32'h0, 0, 32'h0, 1'b0};
    per_ack   = 1'b0;
    per_rdata = 32'h0;
    per_err   = 1'b0;
    forever begin
      @(negedge HCLK);
      per_ack = 1'b0;
      per_err = 1'b0;
      if (!per_req) begin
        serving = 1'b0;
      end else begin
        if (!serving) begin
          serving = 1'b1;
          cnt = 0;
          if (per_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected per_req: got addr %0h want no request", per_addr);
            cur = '{1'b0, 12'h000, 4'h0, 32'h0, 0, 32'h0, 1'b0};
          end else begin
            cur = per_q.pop_front();
            check("per_write", {31'h0, per_write}, {31'h0, cur.wr});
            check("per_addr", {20'h0, per_addr}, {20'h0, cur.paddr});
            check("per_be", {28'h0, per_be}, {28'h0, cur.be});
            if (cur.wr) check("per_wdata", per_wdata, cur.wdata);
          end
        end
        if (cnt == cur.dly) begin
          per_ack   = 1'b1;
          per_rdata = cur.rdata;
          per_err   = cur.perr;
          serving   = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Bus monitor: counts wait states per data phase and checks the completion
  initial begin
    bit       dp;
    int       waits;
    bus_exp_t e;
    dp = 1'b0;
    waits = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp = 1'b0;
      end else begin
        if (dp) begin
          if (!HREADYOUT) begin
            waits++;
          end else begin
            dp = 1'b0;
            if (bus_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected completion: got resp %0h want none", HRESP);
            end else begin
              e = bus_q.pop_front();
              check("HRESP", {30'h0, HRESP}, {30'h0, e.resp});
              check("wait states", waits, e.waits);
              check("HRDATA", HRDATA, e.hrdata);
            end
          end
        end
        if (HREADYOUT && HSEL && HTRANS[1]) begin
          dp = 1'b1;
          waits = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    idx;
    int    dp;
    int    gap_left;
    int    guard;
    bit    rdy;
    item_t it;
    HSEL = 1'b1; HTRANS = HTRANS_IDLE; HADDR = 32'h0; HWRITE = 1'b0;
    HSIZE = HSIZE_WORD; HBURST = 3'b001; HWDATA = 32'h0;

    //  wr    addr          size  wdata          gap dly rdata          perr legal paddr    be     resp         waits hrdata
    add(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 0, 0, 32'h0,         1'b0, 1'b1, 12'h010, 4'hF, HRESP_OKAY,  1, 32'h0000_0000);
    add(1'b0, 32'h0000_0013, 3'd0, 32'h0,         0, 3, 32'h1122_3344, 1'b0, 1'b1, 12'h010, 4'h8, HRESP_OKAY,  4, 32'h1122_3344);
    add(1'b0, 32'h0000_0002, 3'd2, 32'h0,         0, 0, 32'h0,         1'b0, 1'b0, 12'h000, 4'h0, HRESP_ERROR, 1, 32'h1122_3344);
    add(1'b0, 32'h0000_0020, 3'd2, 32'h0,         0, 1, 32'hA5A5_0001, 1'b0, 1'b1, 12'h020, 4'hF, HRESP_OKAY,  2, 32'hA5A5_0001);
    add(1'b0, 32'h0000_0006, 3'd1, 32'h0,         0, 0, 32'hFFFF_FFFF, 1'b1, 1'b1, 12'h004, 4'hC, HRESP_ERROR, 2, 32'hA5A5_0001);
    add(1'b1, 32'h0000_000A, 3'd1, 32'hCAFE_BABE, 2, 0, 32'h0,         1'b0, 1'b1, 12'h008, 4'hC, HRESP_OKAY,  1, 32'hA5A5_0001);
    add(1'b0, 32'h0000_0001, 3'd0, 32'h0,         0, 0, 32'h0000_7700, 1'b0, 1'b1, 12'h000, 4'h2, HRESP_OKAY,  1, 32'h0000_7700);
    add(1'b1, 32'h0000_0800, 3'd2, 32'h1234_5678, 0, 0, 32'h0,         1'b0, 1'b0, 12'h000, 4'h0, HRESP_ERROR, 1, 32'h0000_7700);
    add(1'b0, 32'h0000_0100, 3'd3, 32'h0,         0, 0, 32'h0,         1'b0, 1'b0, 12'h000, 4'h0, HRESP_ERROR, 1, 32'h0000_7700);
    add(1'b0, 32'h0000_0003, 3'd1, 32'h0,         0, 0, 32'h0,         1'b0, 1'b0, 12'h000, 4'h0, HRESP_ERROR, 1, 32'h0000_7700);
    add(1'b1, 32'h0000_07FF, 3'd0, 32'h1100_0000, 0, 2, 32'h0,         1'b0, 1'b1, 12'h7FC, 4'h8, HRESP_OKAY,  3, 32'h0000_7700);
    add(1'b0, 32'h0000_07FC, 3'd2, 32'h0,         0, 0, 32'h89AB_CDEF, 1'b0, 1'b1, 12'h7FC, 4'hF, HRESP_OKAY,  1, 32'h89AB_CDEF);
`ifdef AHB_SLAVE_TIMEOUT_EN
    add(1'b0, 32'h0000_0040, 3'd2, 32'h0,         0, 50, 32'h0,        1'b0, 1'b1, 12'h040, 4'hF, HRESP_ERROR, 5, 32'h89AB_CDEF);
`endif

    #12;
    check("reset HREADYOUT", {31'h0, HREADYOUT}, 32'd1);
    check("reset HRESP", {30'h0, HRESP}, 32'd0);
    check("reset HRDATA", HRDATA, 32'h0);
    check("reset per_req", {31'h0, per_req}, 32'd0);
    check("reset per_write", {31'h0, per_write}, 32'd0);
    check("reset per_addr", {20'h0, per_addr}, 32'h0);
    check("reset per_be", {28'h0, per_be}, 32'h0);
    #5 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // AHB master: hold the address until HREADY, drive HWDATA in the data phase
    idx = 0; dp = -1; gap_left = items[0].gap; guard = 0;
    while ((idx < items.size() || dp >= 0) && guard < 2000) begin
      guard++;
      if (idx < items.size() && gap_left == 0) begin
        it = items[idx];
        HTRANS = HTRANS_NONSEQ; HADDR = it.addr; HWRITE = it.wr; HSIZE = it.size;
      end else begin
        HTRANS = HTRANS_IDLE;
      end
      HWDATA = (dp >= 0 && items[dp].wr) ? items[dp].wdata : 32'h0;
      rdy = HREADYOUT;
      @(posedge HCLK); #1;
      if (rdy) begin
        if (idx < items.size() && gap_left == 0) begin
          it = items[idx];
          bus_q.push_back('{it.resp, it.waits, it.hrdata});
          if (it.legal) per_q.push_back('{it.wr, it.paddr, it.be, it.wdata, it.dly, it.rdata, it.perr});
          dp = idx;
          idx++;
          if (idx < items.size()) gap_left = items[idx].gap;
        end else begin
          dp = -1;
          if (idx < items.size()) gap_left--;
        end
      end
    end
    if (guard >= 2000) begin
      total++;
      bad++;
      $display("FAIL master loop: got %0d cycles want completion before 2000", guard);
    end
    HTRANS = HTRANS_IDLE;
    HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1;
    check("bus completions pending", bus_q.size(), 32'd0);
    check("peripheral requests pending", per_q.size(), 32'd0);

    // Asynchronous reset in the middle of a WAIT state
    per_q.push_back('{1'b0, 12'h030, 4'hF, 32'h0, 100, 32'h0, 1'b0});
    HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_0030; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_IDLE;
    @(posedge HCLK); #1;
    check("wait per_req", {31'h0, per_req}, 32'd1);
    check("wait HREADYOUT", {31'h0, HREADYOUT}, 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    check("async rst per_req", {31'h0, per_req}, 32'd0);
    check("async rst HREADYOUT", {31'h0, HREADYOUT}, 32'd1);
    check("async rst HRESP", {30'h0, HRESP}, 32'd0);
    check("async rst HRDATA", HRDATA, 32'h0);
    check("async rst per_be", {28'h0, per_be}, 32'h0);
    check("async rst per_addr", {20'h0, per_addr}, 32'h0);
    #7 HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    check("post rst per_req", {31'h0, per_req}, 32'd0);
    check("post rst request consumed", per_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
